wash_timer_level_unit: RTL

// - Plant-side timing/sensing stage next to the washing machine FSM.
// - Consumes its actuator commands (fill_valve_on, drained_valve_on, motor_on, spin_en).
// - Returns the status inputs that FSM waits on: water_filled, drained, cycle_time_out, spin_time_out.
// - Models tank level with a counter and runs wash/spin duration timers off a prescaled tick.

---
 rtl/wash_pkg.sv | 26 ++
 rtl/wash_tick_timer.sv | 42 ++++
 rtl/wash_timer_level_unit.sv | 89 ++++++++
 3 files changed

// File: rtl/wash_pkg.sv
// Shared defaults and washing-machine FSM state encodings for the plant-side
// timing/level stage.
package wash_pkg;

    localparam int unsigned WASH_PRESCALE    = 4;
    localparam int unsigned WASH_FILL_LEVEL  = 8;
    localparam int unsigned WASH_CYCLE_TICKS = 20;
    localparam int unsigned WASH_SPIN_TICKS  = 10;

    localparam int unsigned WASH_STATE_W = 3;

    typedef enum logic [WASH_STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_WASH  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_RINSE = 3'd4,
        ST_SPIN  = 3'd5
    } wash_state_e;

    // spin_en is decoded from the controller state with this helper.
    function automatic logic is_spin_state(input wash_state_e s);
        return s == ST_SPIN;
    endfunction

endpackage

// File: rtl/wash_tick_timer.sv
// Duration timer: counts prescaled ticks while enabled, raises a sticky
// time_out after TICKS ticks, and clears synchronously when en drops.
module wash_tick_timer
    import wash_pkg::*;
#(
    parameter int unsigned TICKS = WASH_CYCLE_TICKS
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic tick,
    output logic time_out
);

    localparam int unsigned CW = $clog2(TICKS + 1);

    if (TICKS < 1) begin : g_bad_ticks
        $fatal(1, "wash_tick_timer: TICKS must be >= 1");
    end

    logic [CW-1:0] r_count;
    logic          r_time_out;

    // Count stops at TICKS; timeout is registered on the tick that reaches it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count    <= '0;
            r_time_out <= 1'b0;
        end else if (!en) begin
            r_count    <= '0;
            r_time_out <= 1'b0;
        end else if (tick && (r_count != CW'(TICKS))) begin
            r_count <= r_count + CW'(1);
            if (r_count == CW'(TICKS - 1)) begin
                r_time_out <= 1'b1;
            end
        end
    end

    assign time_out = r_time_out;

endmodule

// File: rtl/wash_timer_level_unit.sv
// Plant model next to the washer FSM: tank level counter, wash/rinse and spin
// duration timers, all paced by a free-running prescaled tick.
module wash_timer_level_unit
    import wash_pkg::*;
#(
    parameter int unsigned PRESCALE    = WASH_PRESCALE,
    parameter int unsigned FILL_LEVEL  = WASH_FILL_LEVEL,
    parameter int unsigned CYCLE_TICKS = WASH_CYCLE_TICKS,
    parameter int unsigned SPIN_TICKS  = WASH_SPIN_TICKS
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              fill_valve_on,
    input  logic                              drained_valve_on,
    input  logic                              motor_on,
    input  logic                              spin_en,
    output logic [$clog2(FILL_LEVEL+1)-1:0]   level,
    output logic                              water_filled,
    output logic                              drained,
    output logic                              cycle_time_out,
    output logic                              spin_time_out
);

    localparam int unsigned LW = $clog2(FILL_LEVEL + 1);
    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    if ((PRESCALE < 1) || (FILL_LEVEL < 1) || (CYCLE_TICKS < 1) || (SPIN_TICKS < 1)) begin : g_bad_param
        $fatal(1, "wash_timer_level_unit: all parameters must be >= 1");
    end

    logic [PW-1:0] r_pre;
    logic [LW-1:0] r_level;
    logic          w_tick;
    logic          w_fill_only;
    logic          w_drain_only;

    assign w_tick = (r_pre == PW'(PRESCALE - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre <= '0;
        end else if (w_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + PW'(1);
        end
    end

    assign w_fill_only  = fill_valve_on && !drained_valve_on;
    assign w_drain_only = drained_valve_on && !fill_valve_on;

    // Level saturates at both ends; both valves open is treated as a hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_level <= '0;
        end else if (w_tick) begin
            if (w_fill_only && (r_level != LW'(FILL_LEVEL))) begin
                r_level <= r_level + LW'(1);
            end else if (w_drain_only && (r_level != '0)) begin
                r_level <= r_level - LW'(1);
            end
        end
    end

    assign level        = r_level;
    assign water_filled = (r_level == LW'(FILL_LEVEL));
    assign drained      = (r_level == '0);

    wash_tick_timer #(
        .TICKS (CYCLE_TICKS)
    ) u_cycle_timer (
        .clk      (clk),
        .rst      (rst),
        .en       (motor_on),
        .tick     (w_tick),
        .time_out (cycle_time_out)
    );

    wash_tick_timer #(
        .TICKS (SPIN_TICKS)
    ) u_spin_timer (
        .clk      (clk),
        .rst      (rst),
        .en       (spin_en),
        .tick     (w_tick),
        .time_out (spin_time_out)
    );

endmodule
